mem_stream_sender: RTL and testbench

MEM_STREAM_SENDER -- requirements
Module: mem_stream_sender

---
 rtl/mem_stream_sender.sv | 140 ++++++++++++++
 tb/tb_mem_stream_sender.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_sender.sv
// Streams characters from one of several memory sources to a UART transmit FIFO.
// Modes: until terminator, fixed length, single character, or looped fixed length.
module mem_stream_sender #(
    parameter int ADDR_BITS  = 7,
    parameter int DATA_BITS  = 7,
    parameter int NUM_SRC    = 2,
    parameter int SEL_BITS   = 1,
    parameter int RD_LATENCY = 1,
    parameter logic [DATA_BITS-1:0] TERMINATOR = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         Start,
    input  logic                         Abort,
    input  logic [1:0]                   Mode,
    input  logic [SEL_BITS-1:0]          SrcSel,
    input  logic [ADDR_BITS-1:0]         StartAddr,
    input  logic [ADDR_BITS:0]           Length,
    input  logic [NUM_SRC*DATA_BITS-1:0] MemData,
    input  logic                         tx_full,
    output logic [ADDR_BITS-1:0]         Address,
    output logic [7:0]                   tx_data,
    output logic                         write_to_uart,
    output logic                         Transmitting,
    output logic                         Done,
    output logic [ADDR_BITS:0]           CharCount
);

    localparam int CW = ADDR_BITS + 1;
    localparam logic [CW-1:0] CAP = CW'(1) << ADDR_BITS;
    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, FETCH, SEND, WRITE, DONE} state_t;

    state_t                 state;
    logic [1:0]             mode_q;
    logic [SEL_BITS-1:0]    sel_q;
    logic [ADDR_BITS-1:0]   base_q;
    logic [CW-1:0]          len_q;
    logic [2:0]             lat_q;
    logic [DATA_BITS-1:0]   slice;
    logic [CW-1:0]          cnt_inc;
    logic                   stop;
    logic                   wrap;

    // Out-of-range selects fall back to source 0.
    always_comb begin
        slice = MemData[DATA_BITS-1:0];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (int'(sel_q) == i) slice = MemData[i*DATA_BITS +: DATA_BITS];
        end
    end

    assign cnt_inc = CharCount + CW'(1);
    assign stop = Abort || (mode_q == 2'd2)
               || (mode_q == 2'd1 && cnt_inc == len_q)
               || (mode_q == 2'd0 && cnt_inc == CAP);
    assign wrap = (mode_q == 2'd3) && (cnt_inc == len_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            Address       <= '0;
            tx_data       <= '0;
            write_to_uart <= 1'b0;
            Transmitting  <= 1'b0;
            Done          <= 1'b0;
            CharCount     <= '0;
            mode_q        <= '0;
            sel_q         <= '0;
            base_q        <= '0;
            len_q         <= '0;
            lat_q         <= '0;
        end else begin
            write_to_uart <= 1'b0;
            Done          <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        mode_q    <= Mode;
                        sel_q     <= SrcSel;
                        base_q    <= StartAddr;
                        len_q     <= Length;
                        Address   <= StartAddr;
                        CharCount <= '0;
                        lat_q     <= '0;
                        if ((Mode == 2'd1 || Mode == 2'd3) && Length == '0) begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            Transmitting <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (Abort) begin
                        state        <= DONE;
                        Done         <= 1'b1;
                        Transmitting <= 1'b0;
                    end else if (lat_q == LAT_LAST) begin
                        tx_data <= 8'(slice);
                        state   <= SEND;
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                SEND: begin
                    if (Abort || (mode_q == 2'd0 && tx_data == 8'(TERMINATOR))) begin
                        state        <= DONE;
                        Done         <= 1'b1;
                        Transmitting <= 1'b0;
                    end else if (!tx_full) begin
                        state         <= WRITE;
                        write_to_uart <= 1'b1;
                    end
                end
                WRITE: begin
                    CharCount <= cnt_inc;
                    Address   <= Address + ADDR_BITS'(1);
                    lat_q     <= '0;
                    if (stop) begin
                        state        <= DONE;
                        Done         <= 1'b1;
                        Transmitting <= 1'b0;
                    end else begin
                        state <= FETCH;
                        if (wrap) begin
                            Address   <= base_q;
                            CharCount <= '0;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_sender.sv
// Directed bench for mem_stream_sender with a scoreboard of expected UART writes.
// Two 128-entry sources feed MemData combinationally from Address.
module tb_mem_stream_sender;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = '0;
    logic [0:0]  src_sel = '0;
    logic [6:0]  start_addr = '0;
    logic [7:0]  length = '0;
    logic [13:0] mem_data;
    logic        tx_full = 1'b0;
    logic [6:0]  address;
    logic [7:0]  tx_data;
    logic        write_to_uart;
    logic        transmitting;
    logic        done;
    logic [7:0]  char_count;

    logic [6:0] mem0 [128];
    logic [6:0] mem1 [128];

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   strobes = 0;

    always #5 clock = ~clock;

    assign mem_data = {mem1[address], mem0[address]};

    mem_stream_sender dut (
        .clock         (clock),
        .reset         (reset),
        .Start         (start),
        .Abort         (abort),
        .Mode          (mode),
        .SrcSel        (src_sel),
        .StartAddr     (start_addr),
        .Length        (length),
        .MemData       (mem_data),
        .tx_full       (tx_full),
        .Address       (address),
        .tx_data       (tx_data),
        .write_to_uart (write_to_uart),
        .Transmitting  (transmitting),
        .Done          (done),
        .CharCount     (char_count)
    );

    always @(negedge clock) begin
        if (reset && write_to_uart) begin
            strobes++;
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL strobe_unexpected observed=%0h@%0d expected=none",
                       tx_data, address);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({address, tx_data} === {e.addr, e.data}) else begin
                    failures++;
                    $error("FAIL strobe_data observed=%0h@%0d expected=%0h@%0d",
                           tx_data, address, e.data, e.addr);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic s, input logic [6:0] a);
        exp_t x;
        x.addr = a;
        x.data = {1'b0, (s ? mem1[a] : mem0[a])};
        exp_q.push_back(x);
    endtask

    task automatic do_start(input logic [1:0] m, input logic s,
                            input logic [6:0] a, input logic [7:0] l);
        mode = m;
        src_sel = s;
        start_addr = a;
        length = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        for (int i = 0; i < max && !done; i++) tick();
        chk(tag, 32'(done), 1);
    endtask

    task automatic wait_strobe(input int max, input string tag);
        for (int i = 0; i < max && !write_to_uart; i++) tick();
        chk(tag, 32'(write_to_uart), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(address), 0);
        chk({tag, "_txd"}, 32'(tx_data), 0);
        chk({tag, "_wr"}, 32'(write_to_uart), 0);
        chk({tag, "_busy"}, 32'(transmitting), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_cnt"}, 32'(char_count), 0);
    endtask

    initial begin
        int c;
        int base;
        logic [7:0] ta;
        logic [6:0] aa;
        logic ok;

        for (int a = 0; a < 128; a++) begin
            mem0[a] = 7'(a + 33);
            mem1[a] = 7'(a ^ 7'h2A) | 7'h01;
        end
        mem1[5] = 7'h48;
        mem1[6] = 7'h49;
        mem1[7] = 7'h00;

        #1;
        chk_all_zero("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Mode 0: "HI" then terminator from source 1
        push_exp(1'b1, 7'd5);
        push_exp(1'b1, 7'd6);
        do_start(2'd0, 1'b1, 7'd5, 8'd0);
        chk("busy_fetch", 32'(transmitting), 1);
        c = 1;
        while (!write_to_uart && c < 20) begin
            tick();
            c++;
        end
        chk("first_latency", c, 3);
        wait_done(20, "m0_done");
        chk("m0_count", 32'(char_count), 2);
        chk("m0_busy_in_done", 32'(transmitting), 0);
        tick();
        chk("m0_done_one_cycle", 32'(done), 0);
        chk("m0_count_hold", 32'(char_count), 2);
        chk("m0_queue", exp_q.size(), 0);

        // Mode 1 address wrap
        push_exp(1'b0, 7'd126);
        push_exp(1'b0, 7'd127);
        push_exp(1'b0, 7'd0);
        push_exp(1'b0, 7'd1);
        do_start(2'd1, 1'b0, 7'd126, 8'd4);
        wait_done(40, "wrap_done");
        chk("wrap_count", 32'(char_count), 4);
        chk("wrap_queue", exp_q.size(), 0);
        tick();

        // Mode 1 with back-pressure on the second character
        base = strobes;
        push_exp(1'b0, 7'd20);
        push_exp(1'b0, 7'd21);
        push_exp(1'b0, 7'd22);
        do_start(2'd1, 1'b0, 7'd20, 8'd3);
        wait_strobe(20, "bp_first");
        tx_full = 1'b1;
        tick();
        tick();
        ta = tx_data;
        aa = address;
        chk("bp_txd", 32'(ta), 32'({1'b0, mem0[21]}));
        chk("bp_addr", 32'(aa), 21);
        ok = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (tx_data !== ta || address !== aa || write_to_uart !== 1'b0
                || transmitting !== 1'b1) ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 1);
        tx_full = 1'b0;
        wait_done(40, "bp_done");
        chk("bp_strobes", strobes - base, 3);
        chk("bp_count", 32'(char_count), 3);
        tick();

        // Mode 3 loop, abort in FETCH of the 8th character
        base = strobes;
        for (int i = 0; i < 7; i++) push_exp(1'b1, 7'(40 + (i % 3)));
        do_start(2'd3, 1'b1, 7'd40, 8'd3);
        for (int i = 0; i < 60 && strobes < base + 7; i++) tick();
        chk("loop_seven", strobes - base, 7);
        tick();
        chk("loop_fetch_busy", 32'(transmitting), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", 32'(done), 1);
        chk("abort_busy", 32'(transmitting), 0);
        chk("abort_count", 32'(char_count), 1);
        tick();
        tick();
        chk("abort_strobes", strobes - base, 7);
        chk("loop_queue", exp_q.size(), 0);

        // Mode 1 with zero length
        base = strobes;
        do_start(2'd1, 1'b0, 7'd50, 8'd0);
        chk("len0_done", 32'(done), 1);
        chk("len0_busy", 32'(transmitting), 0);
        tick();
        chk("len0_strobes", strobes - base, 0);

        // Start and SrcSel changes mid-run are ignored
        push_exp(1'b0, 7'd60);
        push_exp(1'b0, 7'd61);
        do_start(2'd1, 1'b0, 7'd60, 8'd2);
        tick();
        do_start(2'd2, 1'b1, 7'd100, 8'd9);
        wait_done(30, "ign_done");
        chk("ign_count", 32'(char_count), 2);
        chk("ign_queue", exp_q.size(), 0);
        tick();

        // Mode 2 single character
        push_exp(1'b1, 7'd10);
        do_start(2'd2, 1'b1, 7'd10, 8'd0);
        wait_done(20, "single_done");
        chk("single_count", 32'(char_count), 1);
        chk("single_queue", exp_q.size(), 0);
        tick();

        // Reset asserted in the middle of a WRITE
        base = strobes;
        for (int i = 0; i < 5; i++) push_exp(1'b0, 7'(70 + i));
        do_start(2'd1, 1'b0, 7'd70, 8'd5);
        wait_strobe(20, "rst_strobe");
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        exp_q.delete();
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) reset = 1'b1;
            tick();
            if (done !== 1'b0 || write_to_uart !== 1'b0
                || transmitting !== 1'b0) ok = 1'b0;
        end
        chk("rst_quiet", 32'(ok), 1);
        chk("rst_strobes", strobes - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
